// File: rtl/mips_ctrl_pkg.sv
// Shared control-bundle layout, encodings and stage payload for the MIPS control pipeline.
// Consumers select forwarding vs. interlocking with the FORWARDING_EN macro.
package mips_ctrl_pkg;

    localparam int unsigned CONTROL_SIZE = 8;
    localparam int unsigned REG_W        = 5;

    localparam int unsigned CTRL_ALU_SRC     = 7;
    localparam int unsigned CTRL_REG_DEST_HI = 6;
    localparam int unsigned CTRL_REG_DEST_LO = 5;
    localparam int unsigned CTRL_MEM_READ    = 4;
    localparam int unsigned CTRL_MEM_WRITE   = 3;
    localparam int unsigned CTRL_REG_WRITE   = 2;
    localparam int unsigned CTRL_REG_SRC_HI  = 1;
    localparam int unsigned CTRL_REG_SRC_LO  = 0;

    typedef enum logic [1:0] {
        DEST_RD   = 2'b00,
        DEST_RT   = 2'b01,
        DEST_RA   = 2'b10,
        DEST_NONE = 2'b11
    } reg_dest_e;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_RSVD = 2'b11
    } reg_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic             valid;
        logic             alu_src;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic [1:0]       reg_src;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // Destination register chosen by the RegDest field.
    function automatic logic [REG_W-1:0] resolve_dest(input logic [1:0] sel,
                                                      input logic [REG_W-1:0] rt,
                                                      input logic [REG_W-1:0] rd);
        case (reg_dest_e'(sel))
            DEST_RD: return rd;
            DEST_RT: return rt;
            DEST_RA: return REG_RA;
            default: return '0;
        endcase
    endfunction

    // Forward source for one EX operand; MEM is younger so it wins over WB.
    function automatic logic [1:0] fwd_sel(input stage_t mem, input stage_t wb,
                                           input logic [REG_W-1:0] src);
        if (mem.reg_write && (mem.dest != '0) && (mem.dest == src)) return FWD_MEM;
        if (wb.reg_write && (wb.dest != '0) && (wb.dest == src)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall generation: load-use always, plus EX/MEM RAW interlock
// when FORWARDING_EN is not defined.
module hazard_detect
    import mips_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_dest,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_dest,
    output logic       stall
);

    logic load_use;
    logic raw;

    always_comb begin
        load_use = id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                   ((ex_dest == id_rs) || (ex_dest == id_rt));
        raw      = 1'b0;
`ifndef FORWARDING_EN
        // WB is excluded: the register file writes before it reads.
        raw = id_valid &&
              ((ex_reg_write && (ex_dest != '0) &&
                ((ex_dest == id_rs) || (ex_dest == id_rt))) ||
               (mem_reg_write && (mem_dest != '0) &&
                ((mem_dest == id_rs) || (mem_dest == id_rt))));
`endif
        stall = !flush && (load_use || raw);
    end

`ifdef FORWARDING_EN
    logic unused_raw;
    assign unused_raw = ^{ex_reg_write, mem_reg_write, mem_dest};
`endif

endmodule

// File: rtl/control_pipeline.sv
// EX/MEM/WB control pipeline with load-use stall, flush squash and operand forwarding.
// Define FORWARDING_EN for forwarding; otherwise RAW hazards interlock and forward codes stay 00.
module control_pipeline
    import mips_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] id_ctrl,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       flush,
    output logic       stall,
    output logic       ex_alu_src,
    output logic [4:0] ex_rs,
    output logic [4:0] ex_rt,
    output logic       mem_read,
    output logic       mem_write,
    output logic [4:0] mem_dest,
    output logic       wb_reg_write,
    output logic [1:0] wb_reg_src,
    output logic [4:0] wb_dest,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d;

    // ID->EX capture; anything not accepted becomes an all-zero bubble.
    always_comb begin
        ex_d = BUBBLE;
        if (id_valid && !stall && !flush) begin
            ex_d.valid     = 1'b1;
            ex_d.alu_src   = id_ctrl[CTRL_ALU_SRC];
            ex_d.mem_read  = id_ctrl[CTRL_MEM_READ];
            ex_d.mem_write = id_ctrl[CTRL_MEM_WRITE];
            ex_d.reg_write = id_ctrl[CTRL_REG_WRITE];
            ex_d.reg_src   = id_ctrl[CTRL_REG_SRC_HI:CTRL_REG_SRC_LO];
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.dest      = resolve_dest(id_ctrl[CTRL_REG_DEST_HI:CTRL_REG_DEST_LO],
                                          id_rt, id_rd);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    hazard_detect u_hazard (
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .flush         (flush),
        .ex_valid      (ex_q.valid),
        .ex_mem_read   (ex_q.mem_read),
        .ex_reg_write  (ex_q.reg_write),
        .ex_dest       (ex_q.dest),
        .mem_reg_write (mem_q.reg_write),
        .mem_dest      (mem_q.dest),
        .stall         (stall)
    );

    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
`ifdef FORWARDING_EN
        forward_a = fwd_sel(mem_q, wb_q, ex_q.rs);
        forward_b = fwd_sel(mem_q, wb_q, ex_q.rt);
`endif
    end

    // Bubbles carry all-zero fields, so stage outputs need no extra gating.
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign mem_read     = mem_q.mem_read;
    assign mem_write    = mem_q.mem_write;
    assign mem_dest     = mem_q.dest;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_reg_src   = wb_q.reg_src;
    assign wb_dest      = wb_q.dest;

    logic unused_wb;
    assign unused_wb = ^wb_q;

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
- id_ctrl  in  8  decoder bundle: [7] AluSrc, [6:5] RegDest (00 rd, 01 rt, 10 $31), [4] MemRead, [3] MemWrite, [2] RegWrite, [1:0] RegSrc (00 ALU, 01 memory, 10 pc+4).
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  5 each  ID register fields.
- flush  in  1  taken branch/jump resolved in ID; squash the ID instruction.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_alu_src  out  1  EX ALU operand select.
- ex_rs, ex_rt  out  5 each  EX source registers.
- mem_read, mem_write  out  1 each  MEM data-memory enables.
- mem_dest  out  5  MEM destination register.
- wb_reg_write  out  1  WB register-file write enable.
- wb_reg_src  out  2  WB write-data select.
- wb_dest  out  5  WB destination register.
- forward_a, forward_b  out  2 each  EX operand source: 00 register file, 01 WB, 10 MEM.

Function
REQ-003 Three stage registers (EX, MEM, WB) SHALL each hold valid, control fields and rs/rt/dest.
REQ-004 A bubble SHALL be valid=0 with all control bits 0.
REQ-005 EX destination SHALL be resolved at ID->EX capture: RegDest 00 -> id_rd, 01 -> id_rt, 10 -> 31, 11 -> 0.
REQ-006 MEM and WB SHALL advance every cycle, never stalling.
REQ-007 EX SHALL capture the ID bundle when id_valid=1, stall=0 and flush=0; otherwise it captures a bubble.
REQ-008 Load-use hazard: stall=1 when EX is valid, EX MemRead=1, EX dest != 0, id_valid=1 and EX dest equals id_rs or id_rt.
REQ-009 stall SHALL be combinational, with 0-cycle latency from stage state.
REQ-010 flush SHALL take priority: flush=1 forces stall=0, and EX captures a bubble.
REQ-011 A single load-use hazard SHALL stall exactly one cycle.
REQ-012 Register 0 SHALL never cause a hazard or a forward.
REQ-013 forward_a SHALL be 10 if MEM RegWrite=1, mem_dest != 0 and mem_dest=ex_rs.
- Otherwise it is 01 if WB RegWrite=1, wb_dest != 0 and wb_dest=ex_rs.
- Otherwise it is 00.
- forward_b follows the same rule using ex_rt.
REQ-014 Outputs of a bubble stage SHALL be 0.

Reset
REQ-015 reset SHALL immediately clear all three stages to bubbles, independent of clock.
REQ-016 During reset, every output SHALL be 0, including stall and both forward codes.
REQ-017 A stall or flush in progress when reset asserts SHALL be discarded.
REQ-018 The first capture SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-019 Macro FORWARDING_EN SHALL select between forwarding and interlocking.
REQ-020 With FORWARDING_EN defined: forwarding SHALL follow REQ-013, and stalls SHALL come only from REQ-008.
REQ-021 Without FORWARDING_EN:
- forward_a and forward_b SHALL be tied to 00.
- stall SHALL also assert when an EX or MEM stage with RegWrite=1 and dest != 0 matches id_rs or id_rt.
- A RAW hazard against EX SHALL therefore stall two cycles.
- The WB stage SHALL never stall, because the register file writes before it reads.

Structure
REQ-022 Shared package mips_ctrl_pkg SHALL hold:
- control bit indices and CONTROL_SIZE=8;
- RegDest and RegSrc encodings;
- forward codes;
- REG_RA=31.
REQ-023 Hazard logic SHALL be a sub-module, hazard_detect, which is purely combinational and drives stall.

Verification
REQ-024 lw $5 (EX, MemRead, dest 5) with ID add rs=5 -> stall=1 for one cycle, EX bubble, then add enters EX with forward_a=01.
REQ-025 add $3 in MEM (RegWrite, dest 3) and add $3 in WB, with EX rs=3 -> forward_a=10 (MEM wins); with FORWARDING_EN undefined -> forward_a=00 and a prior 2-cycle stall.
REQ-026 flush=1 while the load-use condition is true -> stall=0, EX bubble next cycle, and no memory or register write from the squashed instruction.
REQ-027 jal (RegDest=10, RegWrite=1, RegSrc=10) -> three cycles later wb_dest=31, wb_reg_src=10, wb_reg_write=1.
REQ-028 lw with dest 0 followed by a use of $0 -> stall=0, forward codes 00.
REQ-029 reset asserted mid-stall, between clock edges -> all outputs 0 immediately; after release, sw (MemWrite) reaches MEM two edges later with mem_write=1.
